// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - sequential single-MAC FIR output engine with rounding and saturation
module fir_mac_seq #(
    parameter int SHIFT = 15,
    parameter int NTAP  = 33
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic [5:0]  tap_sel,
    input  logic [13:0] tap_data,
    input  logic [15:0] coef,
    output logic        busy,
    output logic [15:0] y_out,
    output logic        y_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [5:0]         LAST_IDX = 6'(NTAP - 1);
    localparam logic signed [36:0] HALF     = 37'sd1 <<< (SHIFT - 1);
    localparam logic signed [36:0] SAT_HI   = 37'sd32767;
    localparam logic signed [36:0] SAT_LO   = -37'sd32768;

    logic [1:0]         state_q, state_d;
    logic [5:0]         idx_q, idx_d;
    logic signed [29:0] prod_q, prod_d;
    logic signed [35:0] acc_q, acc_d;
    logic [15:0]        y_out_q, y_out_d;
    logic               y_valid_q, y_valid_d;

    logic signed [29:0] tap_x, coef_x;
    logic signed [35:0] prod_ext;
    logic signed [36:0] acc_rnd, acc_scl;

    assign tap_x    = {{16{tap_data[13]}}, tap_data};
    assign coef_x   = {{14{coef[15]}}, coef};
    assign prod_ext = {{6{prod_q[29]}}, prod_q};

    // Extra headroom bit keeps the rounding offset from wrapping a near-full accumulator.
    assign acc_rnd = {acc_q[35], acc_q} + HALF;
    assign acc_scl = acc_rnd >>> SHIFT;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        prod_d    = prod_q;
        acc_d     = acc_q;
        y_out_d   = y_out_q;
        y_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MAC;
                    idx_d   = 6'd0;
                    prod_d  = '0;
                    acc_d   = '0;
                end
            end
            S_MAC: begin
                // The product pipeline lags one tap, so the add uses last cycle's product.
                prod_d = tap_x * coef_x;
                acc_d  = acc_q + prod_ext;
                idx_d  = idx_q + 6'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_FLUSH;
                    idx_d   = 6'd0;
                end
            end
            S_FLUSH: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (acc_scl > SAT_HI) begin
                    y_out_d = 16'h7fff;
                end else if (acc_scl < SAT_LO) begin
                    y_out_d = 16'h8000;
                end else begin
                    y_out_d = acc_scl[15:0];
                end
                y_valid_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            prod_q    <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            prod_q    <= prod_d;
            acc_q     <= acc_d;
            y_out_q   <= y_out_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign tap_sel = (state_q == S_MAC) ? idx_q : 6'd0;
    assign busy    = (state_q != S_IDLE);
    assign y_out   = y_out_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_fir_mac_seq.sv
// tb/tb_fir_mac_seq.sv - scoreboard bench for fir_mac_seq against a sum-of-products model
module tb_fir_mac_seq;

    localparam int SHIFT = 15;
    localparam int NTAP  = 33;
    localparam int LAT   = 35;

    typedef struct {
        int edge_n;
        int val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  tap_sel;
    logic [13:0] tap_data;
    logic [15:0] coef;
    logic        busy;
    logic [15:0] y_out;
    logic        y_valid;

    logic signed [13:0] taps [0:63];
    logic signed [15:0] coefs [0:63];
    logic signed [13:0] taps_nxt [0:63];
    logic signed [15:0] coefs_nxt [0:63];

    exp_t exp_q [$];
    int   cyc = 0;
    int   e0 = 0;
    bit   act = 1'b0;
    int   last_y = 0;
    int   vcount = 0;
    int   checks = 0;
    int   failures = 0;

    fir_mac_seq #(.SHIFT(SHIFT), .NTAP(NTAP)) dut (
        .clk(clk), .rstn(rstn), .start(start), .tap_sel(tap_sel),
        .tap_data(tap_data), .coef(coef), .busy(busy), .y_out(y_out), .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    assign tap_data = taps[tap_sel];
    assign coef     = coefs[tap_sel];

    task automatic check(input string name, input longint actual, input longint expv);
        checks++;
        if (actual !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expv, cyc);
        end
    endtask

    function automatic int model_y();
        longint acc = 0;
        longint r;
        for (int i = 0; i < NTAP; i++) acc += longint'(taps[i]) * longint'(coefs[i]);
        r = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    // One clock: drive at the falling edge, then update the reference at the rising edge.
    task automatic step(input bit s, input bit r);
        exp_t e;
        int n;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            taps[i]  = taps_nxt[i];
            coefs[i] = coefs_nxt[i];
        end
        start = s;
        rstn  = r;
        @(posedge clk);
        n   = cyc + 1;
        cyc = n;
        if (!r) begin
            act = 1'b0;
            exp_q.delete();
        end else if (s && !(act && n <= e0 + LAT)) begin
            act = 1'b1;
            e0  = n;
            e.edge_n = n + LAT;
            e.val    = model_y();
            exp_q.push_back(e);
        end else if (act && n >= e0 + LAT) begin
            act = 1'b0;
        end
    endtask

    task automatic fill(input int t, input int c);
        for (int i = 0; i < 64; i++) begin
            taps_nxt[i]  = 14'(t);
            coefs_nxt[i] = 16'(c);
        end
    endtask

    task automatic fill_random();
        int mode;
        mode = $urandom_range(0, 5);
        for (int i = 0; i < 64; i++) begin
            taps_nxt[i]  = 14'($urandom);
            coefs_nxt[i] = 16'($urandom);
            if (mode == 0) taps_nxt[i] = (i % 2 == 0) ? 14'sh1fff : 14'sh2000;
            if (mode == 1) coefs_nxt[i] = 16'sh7fff;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 1'b1);
    endtask

    // Monitor: per-cycle control checks plus the output scoreboard.
    always @(posedge clk) begin
        exp_t e;
        int d;
        #1;
        if (!rstn) last_y = 0;
        d = cyc - e0;
        check("busy", busy, act);
        check("tap_sel", tap_sel, (act && d >= 0 && d < NTAP) ? d : 0);
        if (y_valid) begin
            vcount++;
            if (exp_q.size() == 0) begin
                check("spurious_y_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("y_valid_cycle", cyc, e.edge_n);
                check("y_out", $signed(y_out), e.val);
                last_y = e.val;
            end
        end else if (exp_q.size() != 0 && exp_q[0].edge_n <= cyc) begin
            e = exp_q.pop_front();
            check("missing_y_valid", 0, e.edge_n);
        end
        check("y_out_held", $signed(y_out), last_y);
    end

    initial begin
        int v0;
        fill(0, 0);
        for (int i = 0; i < 64; i++) begin
            taps[i]  = '0;
            coefs[i] = '0;
        end

        fill_random();
        step(1'b1, 1'b0);
        step(1'(($urandom)), 1'b0);
        #1;
        check("reset_y_out", $signed(y_out), 0);
        check("reset_y_valid", y_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_tap_sel", tap_sel, 0);
        idle(2);

        fill(1000, 1024);
        v0 = vcount;
        step(1'b1, 1'b1);
        idle(40);
        #1;
        check("nominal_y", $signed(y_out), 1031);
        check("nominal_count", vcount - v0, 1);

        fill(8191, 32767);
        step(1'b1, 1'b1);
        idle(40);
        #1;
        check("pos_sat_y", $signed(y_out), 32767);

        fill(-8192, 32767);
        step(1'b1, 1'b1);
        idle(40);
        #1;
        check("neg_sat_y", $signed(y_out), -32768);

        fill(1000, 1024);
        v0 = vcount;
        step(1'b1, 1'b1);
        idle(9);
        step(1'b1, 1'b1);
        idle(40);
        check("busy_reject_count", vcount - v0, 1);

        fill(-77, 555);
        v0 = vcount;
        step(1'b1, 1'b1);
        idle(34);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        idle(40);
        check("back_to_back_count", vcount - v0, 2);

        fill(1000, 1024);
        v0 = vcount;
        step(1'b1, 1'b1);
        idle(20);
        step(1'b0, 1'b0);
        #1;
        check("abort_busy", busy, 0);
        check("abort_y_out", $signed(y_out), 0);
        idle(40);
        check("abort_count", vcount - v0, 0);

        for (int it = 0; it < 40; it++) begin
            if (!act) fill_random();
            repeat ($urandom_range(1, 45)) begin
                step(($urandom_range(0, 5) == 0), ($urandom_range(0, 60) != 0));
            end
        end
        idle(40);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
